// File: rtl/wb_stage_buf.sv
// Writeback stage buffer: formats load results at enqueue, holds them in a
// DEPTH-entry FIFO in front of the register-file write port, and exposes a
// combinational forwarding search over the buffered entries.
module wb_stage_buf #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_alu_result,
    input  logic [XLEN-1:0]         in_mem_data,
    input  logic [2:0]              in_addr_lo,
    input  logic [2:0]              in_funct3,
    input  logic                    in_mem_to_reg,
    input  logic                    in_reg_write,
    input  logic [REG_ADDR_W-1:0]   in_rd_addr,
    input  logic                    wb_ready,
    output logic [XLEN-1:0]         write_back_data,
    output logic [REG_ADDR_W-1:0]   write_back_addr,
    output logic                    reg_write_back,
    output logic                    wb_valid,
    input  logic [REG_ADDR_W-1:0]   fwd_rs_addr,
    output logic                    fwd_hit,
    output logic [XLEN-1:0]         fwd_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage is deliberately not reset; validity comes from r_count.
    logic [XLEN-1:0]       r_data [DEPTH];
    logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
    logic                  r_we   [DEPTH];

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;
    logic [5:0]    w_shamt;
    logic [2:0]    w_f3;
    logic [XLEN-1:0] w_shift;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_result;
    logic [PW-1:0] w_fidx;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_enq    = in_valid & ~w_full & ~flush;
    assign w_deq    = ~w_empty & wb_ready & ~flush;

    assign in_ready = ~w_full;
    assign wb_valid = ~w_empty;
    assign count    = r_count;

    // Load alignment and extension; 32-bit datapaths ignore addr bit 2 and
    // fold the doubleword/unsigned-word encodings onto LW.
    always_comb begin
        w_shamt = '0;
        w_f3    = in_funct3;
        w_load  = '0;
        if (XLEN == 32) begin
            w_shamt = {1'b0, in_addr_lo[1:0], 3'b000};
            if (in_funct3 == 3'b011 || in_funct3 == 3'b110 || in_funct3 == 3'b111)
                w_f3 = 3'b010;
        end else begin
            w_shamt = {in_addr_lo, 3'b000};
            if (in_funct3 == 3'b111)
                w_f3 = 3'b011;
        end
        w_shift = in_mem_data >> w_shamt;
        case (w_f3)
            3'b000:  w_load = XLEN'($signed(w_shift[7:0]));
            3'b001:  w_load = XLEN'($signed(w_shift[15:0]));
            3'b010:  w_load = XLEN'($signed(w_shift[31:0]));
            3'b100:  w_load = XLEN'(w_shift[7:0]);
            3'b101:  w_load = XLEN'(w_shift[15:0]);
            3'b110:  w_load = XLEN'(w_shift[31:0]);
            default: w_load = w_shift;
        endcase
        w_result = in_mem_to_reg ? w_load : in_alu_result;
    end

    // Pointer and occupancy update; flush clears everything and wins over
    // any same-cycle enqueue or dequeue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            if (w_enq && !w_deq)      r_count <= r_count + 1'b1;
            else if (!w_enq && w_deq) r_count <= r_count - 1'b1;
        end
    end

    // Write the already formatted result into the tail slot.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_data[r_wptr] <= w_result;
            r_rd[r_wptr]   <= in_rd_addr;
            r_we[r_wptr]   <= in_reg_write;
        end
    end

    assign write_back_data = r_data[r_rptr];
    assign write_back_addr = r_rd[r_rptr];
    // wb_valid gates first so an empty FIFO never leaks stale/unknown storage.
    assign reg_write_back  = wb_valid & r_we[r_rptr] & (r_rd[r_rptr] != '0);

    // Walk entries oldest to youngest; later matches overwrite earlier ones
    // so the youngest writer to the queried register wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_fidx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fidx = r_rptr + PW'(i);
            if ((CW'(i) < r_count) && r_we[w_fidx] &&
                (r_rd[w_fidx] == fwd_rs_addr) && (fwd_rs_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[w_fidx];
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Self-checking bench for wb_stage_buf (XLEN=64, DEPTH=2): table-driven load
// formatting vectors, directed corner sequences, and a randomized run
// against a queue-based reference model.
module tb_wb_stage_buf;

    localparam int XLEN  = 64;
    localparam int RW    = 5;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_mem_data;
    logic [2:0]      in_addr_lo;
    logic [2:0]      in_funct3;
    logic            in_mem_to_reg;
    logic            in_reg_write;
    logic [RW-1:0]   in_rd_addr;
    logic            wb_ready;
    logic [XLEN-1:0] write_back_data;
    logic [RW-1:0]   write_back_addr;
    logic            reg_write_back;
    logic            wb_valid;
    logic [RW-1:0]   fwd_rs_addr;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic [$clog2(DEPTH):0] count;

    wb_stage_buf #(.XLEN(XLEN), .REG_ADDR_W(RW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_addr_lo(in_addr_lo), .in_funct3(in_funct3),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_rd_addr(in_rd_addr), .wb_ready(wb_ready),
        .write_back_data(write_back_data), .write_back_addr(write_back_addr),
        .reg_write_back(reg_write_back), .wb_valid(wb_valid),
        .fwd_rs_addr(fwd_rs_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic [63:0] mem;
        logic [2:0]  lo;
        logic [2:0]  f3;
        logic        m2r;
        logic [63:0] alu;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference load formatter: width in bytes plus signedness, extended by masking.
    function automatic logic [63:0] ref_fmt(input logic [63:0] mem, input logic [2:0] lo,
                                            input logic [2:0] f3);
        logic [63:0] s, mask;
        int nbytes;
        bit sgn;
        s = mem >> (8 * int'(lo));
        if (f3 == 3'd3 || f3 == 3'd7) return s;
        nbytes = 1 << int'(f3[1:0]);
        sgn    = (f3[2] == 1'b0);
        mask   = (64'd1 << (8 * nbytes)) - 64'd1;
        s      = s & mask;
        if (sgn && s[8*nbytes-1]) s = s | ~mask;
        return s;
    endfunction

    // One clock: decide handshakes from current inputs and model state,
    // apply them to the model at the edge, return at the following negedge.
    task automatic step();
        bit enq, deq;
        ent_t e;
        enq = in_valid && (mq.size() < DEPTH) && !flush;
        deq = (mq.size() > 0) && wb_ready && !flush;
        e.data = in_mem_to_reg ? ref_fmt(in_mem_data, in_addr_lo, in_funct3) : in_alu_result;
        e.rd   = in_rd_addr;
        e.we   = in_reg_write;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic cmp_model(input string tag);
        logic        eh;
        logic [63:0] ed;
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(mq.size() > 0));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
        if (mq.size() > 0) begin
            chk({tag, ".wb_addr"}, 64'(write_back_addr), 64'(mq[0].rd));
            chk({tag, ".wb_data"}, write_back_data, mq[0].data);
            chk({tag, ".rwb"}, 64'(reg_write_back), 64'(mq[0].we && mq[0].rd != 0));
        end else begin
            chk({tag, ".rwb"}, 64'(reg_write_back), 64'd0);
        end
        eh = 1'b0;
        ed = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].we && mq[i].rd == fwd_rs_addr && fwd_rs_addr != 0) begin
                eh = 1'b1;
                ed = mq[i].data;
                break;
            end
        end
        chk({tag, ".fwd_hit"}, 64'(fwd_hit), 64'(eh));
        chk({tag, ".fwd_data"}, fwd_data, ed);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                         input logic [63:0] alu);
        in_valid      = v;
        in_rd_addr    = rd;
        in_reg_write  = we;
        in_alu_result = alu;
        in_mem_to_reg = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  got_rd[$];
        logic [63:0] got_d[$];

        vecs[0]  = '{64'h8877_6655_4433_2281, 3'd0, 3'b000, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FF81};
        vecs[1]  = '{64'h8877_6655_4433_2281, 3'd0, 3'b100, 1'b1, 64'h0, 64'h0000_0000_0000_0081};
        vecs[2]  = '{64'h8877_6655_4433_2281, 3'd4, 3'b010, 1'b1, 64'h0, 64'hFFFF_FFFF_8877_6655};
        vecs[3]  = '{64'h8877_6655_4433_2281, 3'd2, 3'b001, 1'b1, 64'h0, 64'h0000_0000_0000_4433};
        vecs[4]  = '{64'h8877_6655_4433_2281, 3'd6, 3'b001, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_8877};
        vecs[5]  = '{64'h8877_6655_4433_2281, 3'd6, 3'b101, 1'b1, 64'h0, 64'h0000_0000_0000_8877};
        vecs[6]  = '{64'h8877_6655_4433_2281, 3'd0, 3'b011, 1'b1, 64'h0, 64'h8877_6655_4433_2281};
        vecs[7]  = '{64'h8877_6655_4433_2281, 3'd0, 3'b111, 1'b1, 64'h0, 64'h8877_6655_4433_2281};
        vecs[8]  = '{64'h8877_6655_4433_2281, 3'd4, 3'b110, 1'b1, 64'h0, 64'h0000_0000_8877_6655};
        vecs[9]  = '{64'h8877_6655_4433_2281, 3'd7, 3'b000, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FF88};
        vecs[10] = '{64'h8877_6655_4433_2281, 3'd1, 3'b100, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0022};
        vecs[11] = '{64'hDEAD_BEEF_DEAD_BEEF, 3'd3, 3'b000, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};

        rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b0; fwd_rs_addr = '0;
        in_valid = 1'b0; in_alu_result = '0; in_mem_data = '0; in_addr_lo = '0;
        in_funct3 = '0; in_mem_to_reg = 1'b0; in_reg_write = 1'b0; in_rd_addr = '0;
        repeat (2) @(negedge clk);

        chk("reset.count", 64'(count), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.wb_valid", 64'(wb_valid), 64'd0);
        chk("reset.rwb", 64'(reg_write_back), 64'd0);
        chk("reset.fwd_hit", 64'(fwd_hit), 64'd0);
        chk("reset.fwd_data", fwd_data, 64'd0);
        rst_n = 1'b1;

        // Load formatting table.
        for (int k = 0; k < 12; k++) begin
            wb_ready      = 1'b0;
            in_valid      = 1'b1;
            in_mem_data   = vecs[k].mem;
            in_addr_lo    = vecs[k].lo;
            in_funct3     = vecs[k].f3;
            in_mem_to_reg = vecs[k].m2r;
            in_alu_result = vecs[k].alu;
            in_reg_write  = 1'b1;
            in_rd_addr    = 5'd5;
            fwd_rs_addr   = 5'd5;
            step();
            in_valid = 1'b0;
            #1;
            chk($sformatf("fmt%0d.data", k), write_back_data, vecs[k].exp);
            chk($sformatf("fmt%0d.addr", k), 64'(write_back_addr), 64'd5);
            chk($sformatf("fmt%0d.rwb", k), 64'(reg_write_back), 64'd1);
            chk($sformatf("fmt%0d.fwd", k), fwd_data, vecs[k].exp);
            wb_ready = 1'b1;
            step();
            chk($sformatf("fmt%0d.drain", k), 64'(count), 64'd0);
        end

        // Backpressure fill and in-order drain.
        wb_ready = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 64'hA1); step();
        drive(1'b1, 5'd2, 1'b1, 64'hA2); step();
        chk("bp.count", 64'(count), 64'd2);
        chk("bp.in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 5'd3, 1'b1, 64'hA3); step();
        chk("bp.no_accept", 64'(count), 64'd2);
        chk("bp.head1", 64'(write_back_addr), 64'd1);
        in_valid = 1'b0; wb_ready = 1'b1; #1;
        chk("bp.rwb1", 64'(reg_write_back), 64'd1);
        step();
        chk("bp.head2", 64'(write_back_addr), 64'd2);
        chk("bp.data2", write_back_data, 64'hA2);
        step();
        chk("bp.empty", 64'(count), 64'd0);

        // x0 and non-writing entries.
        wb_ready = 1'b0;
        drive(1'b1, 5'd0, 1'b1, 64'h55); step();
        drive(1'b1, 5'd3, 1'b0, 64'h66); step();
        in_valid = 1'b0; fwd_rs_addr = 5'd0; #1;
        chk("x0.rwb_a", 64'(reg_write_back), 64'd0);
        chk("x0.fwd0", 64'(fwd_hit), 64'd0);
        fwd_rs_addr = 5'd3; #1;
        chk("x0.fwd3", 64'(fwd_hit), 64'd0);
        wb_ready = 1'b1; step();
        chk("x0.rwb_b", 64'(reg_write_back), 64'd0);
        chk("x0.count1", 64'(count), 64'd1);
        step();
        chk("x0.count0", 64'(count), 64'd0);

        // Youngest-match forwarding.
        wb_ready = 1'b0;
        drive(1'b1, 5'd7, 1'b1, 64'h11); step();
        drive(1'b1, 5'd7, 1'b1, 64'h22); step();
        in_valid = 1'b0; fwd_rs_addr = 5'd7; #1;
        chk("fwd.hit7", 64'(fwd_hit), 64'd1);
        chk("fwd.data7", fwd_data, 64'h22);
        fwd_rs_addr = 5'd8; #1;
        chk("fwd.hit8", 64'(fwd_hit), 64'd0);
        chk("fwd.data8", fwd_data, 64'h0);

        // Flush with simultaneous enqueue, starting from count=1.
        wb_ready = 1'b1; step();
        chk("flush.pre", 64'(count), 64'd1);
        wb_ready = 1'b0;
        drive(1'b1, 5'd9, 1'b1, 64'h99);
        flush = 1'b1; #1;
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.wb_valid", 64'(wb_valid), 64'd0);

        // Asynchronous reset mid-stream, then a stream across the pointer wrap.
        drive(1'b1, 5'd1, 1'b1, 64'h1); step();
        drive(1'b1, 5'd2, 1'b1, 64'h2); step();
        in_valid = 1'b0;
        chk("arst.pre", 64'(count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.wb_valid", 64'(wb_valid), 64'd0);
        chk("arst.rwb", 64'(reg_write_back), 64'd0);
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        #1 rst_n = 1'b1;
        wb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 5) drive(1'b1, 5'(11 + k), 1'b1, 64'(100 + k));
            else in_valid = 1'b0;
            step();
            if (reg_write_back) begin
                got_rd.push_back(write_back_addr);
                got_d.push_back(write_back_data);
            end
        end
        chk("wrap.n", 64'(got_rd.size()), 64'd5);
        for (int k = 0; k < 5 && k < got_rd.size(); k++) begin
            chk($sformatf("wrap.rd%0d", k), 64'(got_rd[k]), 64'(11 + k));
            chk($sformatf("wrap.d%0d", k), got_d[k], 64'(100 + k));
        end
        chk("wrap.count", 64'(count), 64'd0);

        // Randomized run against the reference model.
        for (int c = 0; c < 500; c++) begin
            in_valid      = ($urandom_range(3) != 0);
            wb_ready      = ($urandom_range(2) != 0);
            flush         = ($urandom_range(15) == 0);
            in_rd_addr    = 5'($urandom_range(7));
            in_reg_write  = ($urandom_range(4) != 0);
            in_mem_to_reg = $urandom_range(1);
            in_funct3     = 3'($urandom_range(7));
            in_addr_lo    = 3'($urandom_range(7));
            in_mem_data   = {$urandom, $urandom};
            in_alu_result = {$urandom, $urandom};
            fwd_rs_addr   = 5'($urandom_range(7));
            #1;
            cmp_model($sformatf("rnd%0d", c));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
